rx_fifo_sync_param: RTL and testbench

Single-clock, parametrised receive FIFO for the PCS receive datapath, the same-clock successor of the 2x receive FIFO. It buffers DATA_W-bit words whose MSB is a sync marker and presents them fall-through to the consumer. When the fill level reaches a programmable threshold it drains the oldest words on its own, so writes are never lost. It also captures the remote block-lock field from consumed marker words.

---
 rtl/rx_fifo_sync_param_if.sv | 33 +++
 rtl/rx_fifo_sync_param.sv | 92 +++++++++
 tb/tb_rx_fifo_sync_param.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rx_fifo_sync_param_if.sv
// Write/read handshake bundle for rx_fifo_sync_param.
// master: producer+consumer side (en_wr, data_wr, pop_rd out); slave: FIFO.
interface rx_fifo_sync_param_if #(
  parameter int DATA_W = 25
);
  logic              en_wr;
  logic [DATA_W-1:0] data_wr;
  logic              pop_rd;
  logic              canpop;
  logic              data_valid;
  logic [DATA_W-2:0] data_rd;
  logic              issync;

  modport master (
    output en_wr,
    output data_wr,
    output pop_rd,
    input  canpop,
    input  data_valid,
    input  data_rd,
    input  issync
  );

  modport slave (
    input  en_wr,
    input  data_wr,
    input  pop_rd,
    output canpop,
    output data_valid,
    output data_rd,
    output issync
  );
endinterface

// File: rtl/rx_fifo_sync_param.sv
// Single-clock fall-through RX FIFO with auto-drain at AFULL_LVL and
// remote block-lock capture from consumed marker words.
// Ports: clk, reset_n (sync, active low), bus (slave: en_wr/data_wr/pop_rd
// in; canpop/data_valid/data_rd/issync out), dissync, level, full,
// out_blocklock_remote(_en), drop_cnt.
// Macro RXFIFO_DROP_CNT_EN: builds the saturating drained-word counter.
module rx_fifo_sync_param #(
  parameter int DATA_W    = 25,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 8,
  parameter int LOCK_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  rx_fifo_sync_param_if.slave bus,
  output logic              dissync,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic [LOCK_W-1:0] out_blocklock_remote,
  output logic              out_blocklock_remote_en,
  output logic [15:0]       drop_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LVL_DEPTH =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_AFULL =
    (ADDR_W+1)'(AFULL_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [DATA_W-1:0] head;
  logic              canpop;
  logic              drain;
  logic              adv;

  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == LVL_DEPTH);
  assign canpop = (level != '0);
  assign head   = mem[rd_ptr[ADDR_W-1:0]];

  // Drain only when no pop, so one advance per cycle at most.
  assign drain = (level >= LVL_AFULL) & ~bus.pop_rd;
  assign adv   = canpop & (bus.pop_rd | drain);

  assign bus.canpop     = canpop;
  assign bus.data_valid = canpop;
  assign bus.data_rd    = head[DATA_W-2:0];
  assign bus.issync     = head[DATA_W-1] & canpop;

  // Full+write always advances rd_ptr too, so the overwritten
  // slot is the head consumed in that same cycle.
  always_ff @(posedge clk) begin
    if (bus.en_wr) begin
      mem[wr_ptr[ADDR_W-1:0]] <= bus.data_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      dissync                 <= 1'b0;
      out_blocklock_remote    <= '1;
      out_blocklock_remote_en <= 1'b0;
    end else begin
      if (bus.en_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      dissync <= drain & canpop;
      out_blocklock_remote_en <= adv & head[DATA_W-1];
      if (adv && head[DATA_W-1]) begin
        out_blocklock_remote <= head[LOCK_W-1:0];
      end
    end
  end

`ifdef RXFIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drain && canpop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign drop_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_rx_fifo_sync_param.sv
// Scoreboard bench for rx_fifo_sync_param: queue model of the FIFO,
// two instances (AFULL_LVL 8 and 16) sharing clk and reset_n.
module tb_rx_fifo_sync_param;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rx_fifo_sync_param_if #(.DATA_W(25)) bus_a ();
  rx_fifo_sync_param_if #(.DATA_W(25)) bus_b ();

  logic        dis_a, dis_b, full_a, full_b;
  logic [4:0]  lvl_a, lvl_b;
  logic [7:0]  bl_a, bl_b;
  logic        ble_a, ble_b;
  logic [15:0] drop_a, drop_b;

  rx_fifo_sync_param #(.AFULL_LVL(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a),
    .dissync(dis_a), .level(lvl_a), .full(full_a),
    .out_blocklock_remote(bl_a),
    .out_blocklock_remote_en(ble_a),
    .drop_cnt(drop_a)
  );

  rx_fifo_sync_param #(.AFULL_LVL(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b),
    .dissync(dis_b), .level(lvl_b), .full(full_b),
    .out_blocklock_remote(bl_b),
    .out_blocklock_remote_en(ble_b),
    .drop_cnt(drop_b)
  );

  int sel = 0;
  wire [4:0]  m_lvl  = sel != 0 ? lvl_b : lvl_a;
  wire        m_full = sel != 0 ? full_b : full_a;
  wire        m_cp   = sel != 0 ? bus_b.canpop : bus_a.canpop;
  wire        m_dv   = sel != 0 ? bus_b.data_valid : bus_a.data_valid;
  wire [23:0] m_rd   = sel != 0 ? bus_b.data_rd : bus_a.data_rd;
  wire        m_is   = sel != 0 ? bus_b.issync : bus_a.issync;
  wire        m_dis  = sel != 0 ? dis_b : dis_a;
  wire [7:0]  m_bl   = sel != 0 ? bl_b : bl_a;
  wire        m_ble  = sel != 0 ? ble_b : ble_a;
  wire [15:0] m_drop = sel != 0 ? drop_b : drop_a;

  int total = 0;
  int bad = 0;

  logic [24:0] q[$];
  logic        e_dis;
  logic [7:0]  e_bl;
  logic        e_ble;
  logic [15:0] e_drop;
  int          wcnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    bus_a.en_wr = 1'b0; bus_a.pop_rd = 1'b0; bus_a.data_wr = '0;
    bus_b.en_wr = 1'b0; bus_b.pop_rd = 1'b0; bus_b.data_wr = '0;
  endtask

  task automatic do_reset(input int which);
    @(negedge clk);
    sel = which;
    idle_all();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    e_dis = 1'b0; e_bl = 8'hFF; e_ble = 1'b0;
    e_drop = 16'h0; wcnt = 0;
    chk("rst_level", m_lvl, 0);
    chk("rst_canpop", m_cp, 0);
    chk("rst_valid", m_dv, 0);
    chk("rst_issync", m_is, 0);
    chk("rst_full", m_full, 0);
    chk("rst_dissync", m_dis, 0);
    chk("rst_bl", m_bl, 8'hFF);
    chk("rst_bl_en", m_ble, 0);
    chk("rst_drop", m_drop, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input int which, input logic en,
                      input logic [24:0] d, input logic pop);
    int afull, lvl;
    logic drn, adv;
    logic [24:0] h;
    afull = (which != 0) ? 16 : 8;
    @(negedge clk);
    sel = which;
    idle_all();
    if (which != 0) begin
      bus_b.en_wr = en; bus_b.data_wr = d; bus_b.pop_rd = pop;
    end else begin
      bus_a.en_wr = en; bus_a.data_wr = d; bus_a.pop_rd = pop;
    end
    #1;
    lvl = q.size();
    chk("level", m_lvl, lvl);
    chk("canpop", m_cp, lvl > 0);
    chk("valid", m_dv, lvl > 0);
    chk("full", m_full, lvl == 16);
    if (lvl > 0) begin
      chk("data_rd", m_rd, q[0][23:0]);
      chk("issync", m_is, q[0][24]);
    end else begin
      chk("issync", m_is, 0);
    end
    drn = (lvl >= afull) && !pop;
    adv = (lvl > 0) && (pop || drn);
    e_ble = 1'b0;
    if (adv) begin
      h = q.pop_front();
      if (h[24]) begin
        e_bl = h[7:0];
        e_ble = 1'b1;
      end
    end
    e_dis = drn && (lvl > 0);
`ifdef RXFIFO_DROP_CNT_EN
    if (e_dis && e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
`endif
    if (en) begin
      q.push_back(d);
      wcnt++;
    end
    @(posedge clk);
    #1;
    chk("dissync", m_dis, e_dis);
    chk("bl", m_bl, e_bl);
    chk("bl_en", m_ble, e_ble);
    chk("drop_cnt", m_drop, e_drop);
    if (which == 0) begin
      chk("wrap", dut_a.wr_ptr[4], (wcnt >> 4) & 1);
    end
  endtask

  initial begin
    idle_all();
    repeat (2) @(posedge clk);

    // basic fill, no pops
    do_reset(0);
    for (int i = 1; i <= 3; i++) step(0, 1'b1, 25'(i), 1'b0);
    step(0, 1'b0, '0, 1'b0);

    // auto-drain at level 8
    do_reset(0);
    for (int i = 0; i < 12; i++) step(0, 1'b1, 25'(16 + i), 1'b0);
    while (q.size() > 0) step(0, 1'b0, '0, 1'b1);
    step(0, 1'b0, '0, 1'b0);
    step(0, 1'b0, '0, 1'b1);

    // marker capture, then non-marker pop
    do_reset(0);
    step(0, 1'b1, 25'h1000055, 1'b0);
    step(0, 1'b0, '0, 1'b0);
    step(0, 1'b0, '0, 1'b1);
    step(0, 1'b1, 25'h0000077, 1'b0);
    step(0, 1'b0, '0, 1'b1);
    step(0, 1'b0, '0, 1'b0);

    // write+pop across pointer wrap
    do_reset(0);
    step(0, 1'b1, 25'h0000100, 1'b0);
    for (int i = 0; i < 40; i++) step(0, 1'b1, 25'(32'h200 + i), 1'b1);
    step(0, 1'b0, '0, 1'b1);

    // reset at level 5
    do_reset(0);
    for (int i = 0; i < 5; i++) step(0, 1'b1, 25'(32'h300 + i), 1'b0);
    do_reset(0);
    step(0, 1'b1, 25'h0000ABC, 1'b0);
    step(0, 1'b0, '0, 1'b0);

    // AFULL_LVL = DEPTH: full plus write
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1, 1'b1, 25'(32'h400 + i), 1'b0);
    step(1, 1'b1, 25'h00000AA, 1'b0);
    step(1, 1'b0, '0, 1'b0);
    while (q.size() > 0) step(1, 1'b0, '0, 1'b1);
    step(1, 1'b0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
